matrix_scanner: RTL
===================

# matrix_scanner

Row-scanning reader for an N×N momentary-switch matrix laid over the Game of Life LED array. It is the input-side counterpart of the LED array driver: it drives one row at a time, senses the column lines, debounces every switch, and presents a stable N*N `cells` bitmap using the same bit mapping the driver consumes. It also emits single-cycle press events that the game core uses to toggle cells.

## Interface
- `N`, 8, matrix dimension (rows = cols = N)
- `SETTLE_CYCLES`, 4, cycles a row is driven before sampling; legal range ≥3
- `DEBOUNCE_SCANS`, 3, consecutive disagreeing samples required to change a cell; legal range ≥1
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `ena`  in  1  scan enable
- `rows`  out  N  one-hot row drive, active-high; all-zero when idle
- `cols`  in  N  raw column sense, asynchronous to `clk`
- `x`  out  $clog2(N)+1  index of the row currently driven
- `cells`  out  N*N  debounced state; `cells[N*r + c]` is the switch at row r, column c
- `press_valid`  out  1  one-cycle pulse on a debounced 0→1 transition
- `press_row`, `press_col`  out  $clog2(N) each  coordinates of the reported press
- `scan_done`  out  1  one-cycle pulse when the row N-1 sample completes

## Operation
- `cols` passes through a 2-flop synchronizer before any use.
- FSM states:
  - S_IDLE: `rows`=0, `x`=0, settle counter=0. Move to S_SETTLE when `ena`=1.
  - S_SETTLE: `rows`=onehot(`x`). The counter increments each cycle. After SETTLE_CYCLES cycles, move to S_SAMPLE.
  - S_SAMPLE: `rows` is still driven. Synced `cols` is applied to the N debouncers of row `x`. `x` advances, wrapping from N-1 to 0. The state returns to S_SETTLE with the counter cleared.
- Debouncer for each cell, updated only in S_SAMPLE of its row:
  - If sample == stable, count=0.
  - Otherwise, count+1. When count+1 == DEBOUNCE_SCANS, stable takes the sample and count=0.
- A 0→1 stable change asserts `press_valid` in the cycle after S_SAMPLE, with that row/col.
- If several columns in one row rise in the same sample, every cell updates. Only the lowest column is reported; the others produce no event.
- 1→0 changes update `cells` without an event.
- `ena`=0 in any state forces S_IDLE on the next edge. A partial row is discarded; `cells` and debounce counts are retained. Re-enable always starts at row 0 with a full settle.
- A `scan_done` pulse coincides with the S_SAMPLE→S_SETTLE transition out of row N-1, and is registered in the cycle after.

## Timing
- Reset values: `rows`=0, `x`=0, `cells`=0, `press_valid`=0, `press_row`=`press_col`=0, `scan_done`=0, all counts=0, synchronizer=0, state S_IDLE.
- Row period is SETTLE_CYCLES+1 cycles; frame period is N*(SETTLE_CYCLES+1) cycles (40 at defaults).
- `rows` and `x` are registered. Row r is driven for exactly SETTLE_CYCLES+1 cycles starting the cycle after entering S_SETTLE.
- Sampling occurs at least 3 edges after the row change, which covers the synchronizer plus one margin cycle.
- Press latency: `cells` and `press_valid` update 1 cycle after the DEBOUNCE_SCANS-th agreeing sample.
- Reset asserted mid-scan clears everything immediately. Scanning resumes at row 0 after release if `ena`=1.

## Structure
- `matrix_scanner_pkg`: `scan_state_t` enum {S_IDLE, S_SETTLE, S_SAMPLE}, plus a helper function computing count width from DEBOUNCE_SCANS.
- Sub-module `cell_debouncer`: one instance per cell, N*N instances via generate.
  - Ports: clk, rst, sample_en, sample, stable, rise.
  - The top-level module owns the FSM, synchronizer, priority encoder and output registers.

## Test plan
All scenarios use defaults (N=8, SETTLE=4, DEBOUNCE=3) with a behavioral switch-matrix model that drives `cols[c]` = `rows[r]` & pressed[r][c].
1. Reset, then `ena`=1 → `rows`=8'b00000001 for 5 cycles, then 8'b00000010, and so on. `scan_done` pulses every 40 cycles; `cells`=0 throughout.
2. Hold (r=2,c=5) → `cells[21]`=1 after the 3rd row-2 sample. `press_valid` pulses once with `press_row`=2 and `press_col`=5.
3. Bounce: (2,5) pressed for 2 scans then released → `cells` stays 0 and `press_valid` never asserts.
4. Release after a stable press, held 3 scans → `cells[21]` returns to 0 and no `press_valid` occurs.
5. Simultaneous press (4,1) and (4,6) → `cells[33]` and `cells[38]` rise in the same cycle. One `press_valid` occurs, with `press_col`=1.
6. `ena` dropped mid-row 3 → `rows`=0 next cycle and `cells` is retained. On re-enable, row 0 is driven for a full 5 cycles. Async `rst` mid-scan clears all outputs within the same cycle.

Source files
------------

// File: rtl/matrix_scanner_pkg.sv
// Shared types and sizing helpers for the switch-matrix scanner.
package matrix_scanner_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE
  } scan_state_t;

  // Counter only needs to reach DEBOUNCE_SCANS-1; keep at least one bit.
  function automatic int count_width(input int debounce_scans);
    return (debounce_scans < 2) ? 1 : $clog2(debounce_scans);
  endfunction

endpackage

// File: rtl/matrix_scanner_if.sv
// Row drive, column sense and debounced-state bundle of the switch-matrix scanner.
interface matrix_scanner_if #(
  parameter int N = 8
);
  localparam int RW = $clog2(N);

  logic             ena;
  logic [N-1:0]     rows;
  logic [N-1:0]     cols;
  logic [RW:0]      x;
  logic [N*N-1:0]   cells;
  logic             press_valid;
  logic [RW-1:0]    press_row;
  logic [RW-1:0]    press_col;
  logic             scan_done;

  modport master (
    output ena, cols,
    input  rows, x, cells, press_valid, press_row, press_col, scan_done
  );

  modport slave (
    input  ena, cols,
    output rows, x, cells, press_valid, press_row, press_col, scan_done
  );
endinterface

// File: rtl/matrix_scanner_cell_debouncer.sv
// Per-switch debouncer: the stable state flips only after DEBOUNCE_SCANS
// consecutive disagreeing samples; rise flags the sample that makes a 0->1 flip.
module cell_debouncer
  import matrix_scanner_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic sample,
  output logic stable,
  output logic rise
);
  localparam int CW = count_width(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_SCANS - 1);

  logic          stable_q, stable_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    stable_d = stable_q;
    count_d  = count_q;
    rise     = 1'b0;
    if (sample_en) begin
      if (sample == stable_q) begin
        count_d = '0;
      end else if (count_q == LAST) begin
        stable_d = sample;
        count_d  = '0;
        rise     = sample;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_q <= 1'b0;
      count_q  <= '0;
    end else begin
      stable_q <= stable_d;
      count_q  <= count_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/matrix_scanner.sv
// Row-scanning reader for an N x N switch matrix: drives one row at a time,
// debounces every switch and reports single-cycle press events.
module matrix_scanner
  import matrix_scanner_pkg::*;
#(
  parameter int N              = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic               clk,
  input  logic               rst,
  matrix_scanner_if.slave    bus
);
  localparam int RW = $clog2(N);
  localparam int XW = RW + 1;
  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [N-1:0]  ROW_ONE = {{(N-1){1'b0}}, 1'b1};

  scan_state_t     state_q;
  logic [CW-1:0]   cnt_q;
  logic [XW-1:0]   x_q, x_d;
  logic [N-1:0]    rows_q;
  logic [N-1:0]    sync1_q, sync2_q;
  logic            press_valid_q, scan_done_q;
  logic [RW-1:0]   press_row_q, press_col_q;

  logic            sampling;
  logic [N-1:0]    row_en;
  logic [N*N-1:0]  cells_w, rise_all;
  logic [N-1:0]    row_rise;
  logic [RW-1:0]   col_enc;

  // Column lines are asynchronous to clk; nothing downstream sees them unsynced.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.cols;
      sync2_q <= sync1_q;
    end
  end

  assign sampling = (state_q == S_SAMPLE) && bus.ena;

  always_comb begin
    x_d = (x_q == XW'(N - 1)) ? '0 : x_q + 1'b1;
    for (int r = 0; r < N; r++) begin
      row_en[r] = sampling && (x_q == XW'(r));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N * N; gi++) begin : g_cell
      cell_debouncer #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_cell (
        .clk       (clk),
        .rst       (rst),
        .sample_en (row_en[gi / N]),
        .sample    (sync2_q[gi % N]),
        .stable    (cells_w[gi]),
        .rise      (rise_all[gi])
      );
    end
  endgenerate

  // Only the sampled row can rise, so OR-folding rows isolates its rises.
  always_comb begin
    row_rise = '0;
    for (int r = 0; r < N; r++) begin
      row_rise = row_rise | rise_all[N*r +: N];
    end
    col_enc = '0;
    for (int c = N - 1; c >= 0; c--) begin
      if (row_rise[c]) col_enc = RW'(c);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      x_q           <= '0;
      rows_q        <= '0;
      press_valid_q <= 1'b0;
      press_row_q   <= '0;
      press_col_q   <= '0;
      scan_done_q   <= 1'b0;
    end else begin
      press_valid_q <= 1'b0;
      scan_done_q   <= 1'b0;
      if (!bus.ena) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        x_q     <= '0;
        rows_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_SETTLE;
            cnt_q   <= '0;
            rows_q  <= ROW_ONE << x_q;
          end
          S_SETTLE: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == SETTLE_LAST) state_q <= S_SAMPLE;
          end
          S_SAMPLE: begin
            state_q <= S_SETTLE;
            cnt_q   <= '0;
            x_q     <= x_d;
            rows_q  <= ROW_ONE << x_d;
            if (|row_rise) begin
              press_valid_q <= 1'b1;
              press_row_q   <= x_q[RW-1:0];
              press_col_q   <= col_enc;
            end
            if (x_q == XW'(N - 1)) scan_done_q <= 1'b1;
          end
          default: begin
            state_q <= S_IDLE;
            rows_q  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.rows        = rows_q;
  assign bus.x           = x_q;
  assign bus.cells       = cells_w;
  assign bus.press_valid = press_valid_q;
  assign bus.press_row   = press_row_q;
  assign bus.press_col   = press_col_q;
  assign bus.scan_done   = scan_done_q;

endmodule
